// File: rtl/dsp_mult_scheduler_if.sv
// Requester/result handshake bundle for dsp_mult_scheduler.
// Requesters A and B present operations here. The scheduler returns results here.
// Modport slave is the scheduler side. Modport master is the requester/consumer side.
interface dsp_mult_scheduler_if;
  logic        a_valid;
  logic        a_ready;
  logic [1:0]  a_mode;
  logic [36:0] a_in1;
  logic [36:0] a_in2;

  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_mode;
  logic [36:0] b_in1;
  logic [36:0] b_in2;

  logic        res_valid;
  logic        res_ready;
  logic [73:0] res_data;
  logic        res_id;

  modport slave (
    input  a_valid, a_mode, a_in1, a_in2,
    input  b_valid, b_mode, b_in1, b_in2,
    input  res_ready,
    output a_ready, b_ready,
    output res_valid, res_data, res_id
  );

  modport master (
    output a_valid, a_mode, a_in1, a_in2,
    output b_valid, b_mode, b_in1, b_in2,
    output res_ready,
    input  a_ready, b_ready,
    input  res_valid, res_data, res_id
  );
endinterface

// File: rtl/dsp_mult_scheduler.sv
// dsp_mult_scheduler: shares one combinational multiplier between two requesters.
// The scheduler arbitrates round-robin and holds the operands for MULT_LAT cycles.
// When the multiplier mode changes, it first drives the new mode with zero operands
// for MODE_SWITCH_GAP cycles. The captured product is returned with the requester ID.
// Optional macro DSP_SCHED_STATS_EN adds saturating op/stall counters.
module dsp_mult_scheduler #(
  parameter int MULT_LAT        = 1,
  parameter int MODE_SWITCH_GAP = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  dsp_mult_scheduler_if.slave bus,
  output logic [1:0]          mult_mode,
  output logic [36:0]         mult_in1,
  output logic [36:0]         mult_in2,
  input  logic [73:0]         mult_out,
  output logic                busy
`ifdef DSP_SCHED_STATS_EN
  ,
  output logic [15:0]         stat_a_ops,
  output logic [15:0]         stat_b_ops,
  output logic [15:0]         stat_stall
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Counters hold "cycles remaining minus one".
  localparam logic [3:0] LAT_LOAD = 4'(MULT_LAT - 1);
  localparam logic [3:0] GAP_LOAD = (MODE_SWITCH_GAP > 0) ? 4'(MODE_SWITCH_GAP - 1) : 4'd0;
  localparam bit         GAP_EN   = (MODE_SWITCH_GAP > 0);

  // Mode 11 is an alias of 10 (4x 9x9). Only the canonical code reaches the multiplier.
  function automatic logic [1:0] canon_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b10 : m;
  endfunction

  state_t      state_q,     state_d;
  logic [3:0]  cnt_q,       cnt_d;
  logic [1:0]  op_mode_q,   op_mode_d;
  logic [36:0] op_in1_q,    op_in1_d;
  logic [36:0] op_in2_q,    op_in2_d;
  logic        op_id_q,     op_id_d;
  logic        rr_last_q,   rr_last_d;
  logic [1:0]  last_mode_q, last_mode_d;
  logic [73:0] res_data_q,  res_data_d;
  logic        res_id_q,    res_id_d;

  logic        grant_a;
  logic        grant_b;
  logic        a_ready;
  logic        b_ready;
  logic [1:0]  sel_mode;
  logic [36:0] sel_in1;
  logic [36:0] sel_in2;

  // Round-robin pick: a lone requester wins, otherwise the one not served last.
  always_comb begin
    grant_a  = bus.a_valid && (!bus.b_valid || rr_last_q);
    grant_b  = bus.b_valid && (!bus.a_valid || !rr_last_q);
    sel_mode = grant_b ? canon_mode(bus.b_mode) : canon_mode(bus.a_mode);
    sel_in1  = grant_b ? bus.b_in1 : bus.a_in1;
    sel_in2  = grant_b ? bus.b_in2 : bus.a_in2;
  end

  // Scheduler FSM next-state and register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_mode_d   = op_mode_q;
    op_in1_d    = op_in1_q;
    op_in2_d    = op_in2_q;
    op_id_d     = op_id_q;
    rr_last_d   = rr_last_q;
    last_mode_d = last_mode_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    a_ready     = 1'b0;
    b_ready     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        a_ready = grant_a;
        b_ready = grant_b;
        if (grant_a || grant_b) begin
          op_mode_d = sel_mode;
          op_in1_d  = sel_in1;
          op_in2_d  = sel_in2;
          op_id_d   = grant_b;
          rr_last_d = grant_b;
          if (GAP_EN && (sel_mode != last_mode_q)) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_EXEC;
            cnt_d   = LAT_LOAD;
          end
        end
      end

      ST_GAP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_EXEC;
          cnt_d   = LAT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_data_d  = mult_out;
          res_id_d    = op_id_q;
          last_mode_d = op_mode_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RESP: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and operand registers. An async reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      op_mode_q   <= 2'b00;
      op_in1_q    <= '0;
      op_in2_q    <= '0;
      op_id_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      last_mode_q <= 2'b00;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_mode_q   <= op_mode_d;
      op_in1_q    <= op_in1_d;
      op_in2_q    <= op_in2_d;
      op_id_q     <= op_id_d;
      rr_last_q   <= rr_last_d;
      last_mode_q <= last_mode_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  // Multiplier drive. The mode leads during GAP so the datapath can settle.
  // Otherwise the mode rests on the last executed mode, and operands are zero outside EXEC.
  always_comb begin
    mult_mode = ((state_q == ST_GAP) || (state_q == ST_EXEC)) ? op_mode_q : last_mode_q;
    mult_in1  = (state_q == ST_EXEC) ? op_in1_q : '0;
    mult_in2  = (state_q == ST_EXEC) ? op_in2_q : '0;
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.res_valid = (state_q == ST_RESP);
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign busy          = (state_q != ST_IDLE);

`ifdef DSP_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stat_a_q, stat_a_d;
  logic [15:0] stat_b_q, stat_b_d;
  logic [15:0] stat_s_q, stat_s_d;
  logic        res_hs;
  logic        stall;

  // Count completed results per requester and cycles a requester waits.
  always_comb begin
    stat_a_d = stat_a_q;
    stat_b_d = stat_b_q;
    stat_s_d = stat_s_q;
    res_hs   = (state_q == ST_RESP) && bus.res_ready;
    stall    = (bus.a_valid && !a_ready) || (bus.b_valid && !b_ready);
    if (res_hs && !res_id_q) stat_a_d = sat_inc(stat_a_q);
    if (res_hs &&  res_id_q) stat_b_d = sat_inc(stat_b_q);
    if (stall)               stat_s_d = sat_inc(stat_s_q);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_a_q <= 16'd0;
      stat_b_q <= 16'd0;
      stat_s_q <= 16'd0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
      stat_s_q <= stat_s_d;
    end
  end

  assign stat_a_ops = stat_a_q;
  assign stat_b_ops = stat_b_q;
  assign stat_stall = stat_s_q;
`endif

endmodule

// File: tb/tb_dsp_mult_scheduler.sv
// Testbench for dsp_mult_scheduler (MULT_LAT=1, MODE_SWITCH_GAP=1) with a behavioural multiplier.
module tb_dsp_mult_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mult_mode;
  logic [36:0] mult_in1;
  logic [36:0] mult_in2;
  logic [73:0] mult_out;
  logic        busy;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic [73:0] data;
    logic        id;
  } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  typedef struct {
    logic        a_v;
    logic        b_v;
    logic        hold;
    logic [1:0]  a_mode;
    logic [36:0] a_in1;
    logic [36:0] a_in2;
    logic [1:0]  b_mode;
    logic [36:0] b_in1;
    logic [36:0] b_in2;
    logic        exp_id;
    logic [73:0] exp_data;
    int          exp_lat;
  } vec_t;
  vec_t vecs[9];

  dsp_mult_scheduler_if bus();

`ifdef DSP_SCHED_STATS_EN
  logic [15:0] stat_a_ops, stat_b_ops, stat_stall;
`endif

  dsp_mult_scheduler #(.MULT_LAT(1), .MODE_SWITCH_GAP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mult_mode (mult_mode),
    .mult_in1  (mult_in1),
    .mult_in2  (mult_in2),
    .mult_out  (mult_out),
    .busy      (busy)
`ifdef DSP_SCHED_STATS_EN
    ,
    .stat_a_ops(stat_a_ops),
    .stat_b_ops(stat_b_ops),
    .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: 00 = two packed products, 01 = 27x27, 10/11 = four 9x9 lanes.
  function automatic logic [73:0] mult_model(input logic [1:0] m, input logic [36:0] x,
                                             input logic [36:0] y);
    logic [73:0] r;
    r = '0;
    case (m)
      2'b00: begin
        r[36:0]  = 37'(x[17:0]) * 37'(y[18:0]);
        r[73:37] = 37'(x[35:18]) * 37'(y[36:19]);
      end
      2'b01:   r[53:0] = 54'(x[26:0]) * 54'(y[26:0]);
      default: for (int k = 0; k < 4; k++) r[18*k +: 18] = 18'(x[9*k +: 9]) * 18'(y[9*k +: 9]);
    endcase
    return r;
  endfunction

  always_comb mult_out = mult_model(mult_mode, mult_in1, mult_in2);

  task automatic check(input string nm, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_result actual=%0d required=no_result", bus.res_data);
      end else begin
        sb_e = sb.pop_front();
        check("sb_res_data", bus.res_data, sb_e.data);
        check("sb_res_id", 74'(bus.res_id), 74'(sb_e.id));
      end
    end
  end

  function automatic vec_t mk(input logic av, input logic bv, input logic hold,
                              input logic [1:0] am, input logic [36:0] a1, input logic [36:0] a2,
                              input logic [1:0] bm, input logic [36:0] b1, input logic [36:0] b2,
                              input logic id, input logic [73:0] d, input int lat);
    vec_t v;
    v.a_v = av; v.b_v = bv; v.hold = hold;
    v.a_mode = am; v.a_in1 = a1; v.a_in2 = a2;
    v.b_mode = bm; v.b_in1 = b1; v.b_in2 = b2;
    v.exp_id = id; v.exp_data = d; v.exp_lat = lat;
    return v;
  endfunction

  task automatic wait_grant(input string nm, input logic exp_id, output int t0, output int waited);
    logic got;
    logic gid;
    got = 1'b0; gid = 1'b0; t0 = 0; waited = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.a_ready || bus.b_ready) begin
        got = 1'b1;
        gid = bus.b_ready;
        t0 = cyc;
        waited = k;
        check({nm, "_one_ready"}, 74'(bus.a_ready & bus.b_ready), 74'(0));
      end
    end
    check({nm, "_granted"}, 74'(got), 74'(1));
    check({nm, "_grant_id"}, 74'(gid), 74'(exp_id));
  endtask

  task automatic wait_resp(input string nm, input int t0, input int exp_lat);
    logic seen;
    int   lat;
    seen = 1'b0; lat = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.res_valid) begin
        seen = 1'b1;
        lat = cyc - t0;
      end
    end
    check({nm, "_resp_seen"}, 74'(seen), 74'(1));
    check({nm, "_latency"}, 74'(lat), 74'(exp_lat));
  endtask

  task automatic push_exp(input logic [73:0] d, input logic id);
    exp_t e;
    e.data = d;
    e.id = id;
    sb.push_back(e);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int t0;
    int waited;
    string nm;
    nm = $sformatf("v%0d", i);
    @(posedge clk); #1;
    bus.a_valid = v.a_v; bus.a_mode = v.a_mode; bus.a_in1 = v.a_in1; bus.a_in2 = v.a_in2;
    bus.b_valid = v.b_v; bus.b_mode = v.b_mode; bus.b_in1 = v.b_in1; bus.b_in2 = v.b_in2;
    wait_grant(nm, v.exp_id, t0, waited);
    check({nm, "_grant_same_cycle"}, 74'(waited), 74'(0));
    push_exp(v.exp_data, v.exp_id);
    @(posedge clk); #1;
    if (!v.hold) begin
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
    end
    wait_resp(nm, t0, v.exp_lat);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int waited;

    vecs[0] = mk(1, 0, 0, 2'b01, 1000, 2000, 2'b00, 0, 0, 0, 2000000, 3);
    vecs[1] = mk(1, 0, 0, 2'b01, 7, 9, 2'b00, 0, 0, 0, 63, 2);
    vecs[2] = mk(0, 1, 0, 2'b00, 0, 0, 2'b01, 134217727, 2, 1, 268435454, 2);
    vecs[3] = mk(1, 1, 1, 2'b10, 2, 3, 2'b10, 1538, 2051, 0, 6, 3);
    vecs[4] = mk(1, 1, 1, 2'b10, 2, 3, 2'b10, 1538, 2051, 1, 3145734, 2);
    vecs[5] = mk(1, 1, 1, 2'b10, 511, 511, 2'b10, 1, 1, 0, 261121, 2);
    vecs[6] = mk(1, 1, 0, 2'b10, 1, 1, 2'b10, 10, 10, 1, 100, 2);
    vecs[7] = mk(0, 1, 0, 2'b00, 0, 0, 2'b11, 100, 7, 1, 700, 2);
    vecs[8] = mk(1, 0, 0, 2'b00, 300, 5, 2'b00, 0, 0, 0, 1500, 3);

    bus.a_valid = 1'b0; bus.a_mode = 2'b00; bus.a_in1 = '0; bus.a_in2 = '0;
    bus.b_valid = 1'b0; bus.b_mode = 2'b00; bus.b_in1 = '0; bus.b_in2 = '0;
    bus.res_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_busy", 74'(busy), 74'(0));
    check("rst_res_valid", 74'(bus.res_valid), 74'(0));
    check("rst_res_data", bus.res_data, 74'(0));
    check("rst_res_id", 74'(bus.res_id), 74'(0));
    check("rst_mult_mode", 74'(mult_mode), 74'(0));
    check("rst_mult_in1", 74'(mult_in1), 74'(0));
    check("rst_mult_in2", 74'(mult_in2), 74'(0));
    check("rst_a_ready", 74'(bus.a_ready), 74'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Result held for several cycles while a new A request waits.
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.a_valid = 1'b1; bus.a_mode = 2'b00; bus.a_in1 = 12; bus.a_in2 = 12;
    wait_grant("stall", 1'b0, t0, waited);
    push_exp(74'd144, 1'b0);
    @(posedge clk); #1;
    bus.a_in1 = 11; bus.a_in2 = 11;
    wait_resp("stall", t0, 2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      check("stall_res_valid", 74'(bus.res_valid), 74'(1));
      check("stall_res_data", bus.res_data, 74'd144);
      check("stall_res_id", 74'(bus.res_id), 74'(0));
      check("stall_a_ready", 74'(bus.a_ready), 74'(0));
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("hs_cycle_no_grant", 74'(bus.a_ready), 74'(0));
    @(negedge clk);
    check("grant_after_hs", 74'(bus.a_ready), 74'(1));
    t0 = cyc;
    push_exp(74'd121, 1'b0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    wait_resp("after_stall", t0, 2);

    // Mode 11 after mode 00: gap, canonical 10 on the multiplier. A short A pulse during GAP is never granted.
    @(posedge clk); #1;
    bus.b_valid = 1'b1; bus.b_mode = 2'b11; bus.b_in1 = 3; bus.b_in2 = 5;
    wait_grant("m11", 1'b1, t0, waited);
    push_exp(74'd15, 1'b1);
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    bus.a_valid = 1'b1; bus.a_mode = 2'b01; bus.a_in1 = 5; bus.a_in2 = 5;
    @(negedge clk);
    check("m11_gap_mode", 74'(mult_mode), 74'(2));
    check("m11_gap_in1_zero", 74'(mult_in1), 74'(0));
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    check("m11_exec_mode", 74'(mult_mode), 74'(2));
    check("m11_exec_in1", 74'(mult_in1), 74'(3));
    check("m11_exec_in2", 74'(mult_in2), 74'(5));
    wait_resp("m11", t0, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("dropped_valid_idle", 74'(busy), 74'(0));
    end

    // Reset during EXEC aborts the operation and restores arbitration state.
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_mode = 2'b01; bus.a_in1 = 6; bus.a_in2 = 7;
    wait_grant("abort", 1'b0, t0, waited);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_exec", 74'(mult_in1), 74'(6));
    rst_n = 1'b0;
    #1;
    check("abort_busy", 74'(busy), 74'(0));
    check("abort_res_valid", 74'(bus.res_valid), 74'(0));
    check("abort_mult_in1", 74'(mult_in1), 74'(0));
    check("abort_mult_mode", 74'(mult_mode), 74'(0));
    repeat (2) begin
      @(negedge clk);
      check("abort_no_resp", 74'(bus.res_valid), 74'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.a_valid = 1'b1; bus.a_mode = 2'b00; bus.a_in1 = 40; bus.a_in2 = 50;
    bus.b_valid = 1'b1; bus.b_mode = 2'b00; bus.b_in1 = 1;  bus.b_in2 = 1;
    wait_grant("post_rst", 1'b0, t0, waited);
    push_exp(74'd2000, 1'b0);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    wait_resp("post_rst", t0, 2);

    repeat (3) @(negedge clk);
    check("sb_drained", 74'(sb.size()), 74'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dsp_mult_scheduler.md
Name: dsp_mult_scheduler

Overview:
- Two-requester scheduler for the shared Agilex-style multiplier datapath (inputs `mode[1:0]`, `IN1[36:0]`, `IN2[36:0]`; output `OUT1[73:0]`). It is combinational with latency `MULT_LAT`.
- Arbitrates requests round-robin, registers operands and drives the multiplier.
- Inserts a settle gap when the operating mode changes.
- Returns the registered result with a requester ID over a valid/ready interface.
- Sits between the accumulator/requester logic and the multiplier instance.

Parameters:
- MULT_LAT, 1, cycles operands are held in EXEC before `mult_out` is captured (1..15).
- MODE_SWITCH_GAP, 1, bubble cycles inserted when the canonical mode differs from the last executed mode (0..15).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  A accepted this cycle when a_valid&&a_ready
- a_mode  in  2  A mode: 00=2x(18x19), 01=27x27, 10/11=4x(9x9)
- a_in1  in  37  A operand 1
- a_in2  in  37  A operand 2
- b_valid, b_ready, b_mode, b_in1, b_in2  as A, for requester B
- mult_mode  out  2  to multiplier `mode`
- mult_in1  out  37  to multiplier `IN1`
- mult_in2  out  37  to multiplier `IN2`
- mult_out  in  74  from multiplier `OUT1`
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  74  captured `mult_out`
- res_id  out  1  0=A, 1=B
- busy  out  1  state != IDLE

Behaviour:
- Reset values, applied asynchronously on rst_n low:
  - State IDLE; all registered outputs 0.
  - mult_mode=00, last_mode=00, rr_last=1 (so A wins first).
- Mode canonicalisation: 11 is mapped to 10 on accept. Only 00/01/10 are ever driven on mult_mode.
- FSM states: IDLE, GAP, EXEC, RESP.
- IDLE:
  - a_ready/b_ready are combinational. Only the granted requester sees ready=1.
  - Grant rule: if exactly one is valid, grant it. If both are valid, grant the one != rr_last.
  - On accept: latch mode/in1/in2/id into op regs and set rr_last=id.
  - Next state is GAP if canonical mode != last_mode and MODE_SWITCH_GAP>0; otherwise EXEC.
  - No accept in any other state; both readys are 0 there.
- GAP:
  - mult_mode = new mode; mult_in1/in2 = 0.
  - Counter runs MODE_SWITCH_GAP cycles, then the FSM goes to EXEC.
- EXEC:
  - mult_mode/in1/in2 are driven from op regs; counter runs MULT_LAT cycles.
  - On the last EXEC cycle: res_data<=mult_out, res_id<=op id, last_mode<=op mode, then go to RESP.
- RESP:
  - res_valid=1; res_data/res_id are held stable until res_ready.
  - On res_valid&&res_ready, go to IDLE. The next request is accepted no earlier than the cycle after that.
  - mult_in1/in2 = 0 outside EXEC. mult_mode holds its last value outside GAP/EXEC.
- Latency, accept at cycle T, res_ready tied high:
  - Gap not needed: res_valid at T+1+MULT_LAT.
  - Gap needed: res_valid at T+1+MODE_SWITCH_GAP+MULT_LAT.
- Throughput: one op per (2+gap+MULT_LAT) cycles minimum.
- Boundary conditions:
  - Requester valid may drop before accept: no grant and no state change. Operands are sampled only at the accept edge.
  - Simultaneous valids alternate strictly when both are held high.
  - A request arriving during RESP waits. It is granted in the cycle after the result handshake, not in the same cycle.
  - rst_n asserted mid-operation aborts: no response is issued, and rr_last/last_mode return to reset values.
  - MODE_SWITCH_GAP=0: the GAP state is never entered.

Optional Feature:
- Macro DSP_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_a_ops[15:0], stat_b_ops[15:0], stat_stall[15:0].
  - stat_a_ops/stat_b_ops increment on each result handshake for the respective ID.
  - stat_stall increments each cycle a requester has valid=1 and ready=0.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then a_valid, mode=01, a_in1=1000, a_in2=2000, multiplier model attached, res_ready=1. Required: a_ready same cycle; res_data=2000000, res_id=0; res_valid exactly T+3 (gap 1 + lat 1 for 00->01).
- Second A op, mode=01, in1=7, in2=9. Required: no gap; res_valid at T+2; res_data=63.
- a_valid and b_valid held high, both mode=10. Required: grants alternate A,B,A,B. Each B result has res_id=1 and res_data matches the 4x(9x9) packing, e.g. in1[8:0]=2, in1[17:9]=3 gives res_data[17:0]=6.
- res_ready=0 for 5 cycles in RESP. Required: res_valid, res_data and res_id are stable; a_ready=0 throughout; accept occurs the cycle after the handshake.
- mode=11 request. Required: mult_mode shows 10 during GAP/EXEC.
- rst_n pulsed low during EXEC. Required: immediate return to IDLE, no res_valid, next grant goes to A.
